// File: rtl/pixel_window_buf.sv
// Streaming 3x3 neighbourhood extractor for raster-order pixels.
// A 2*IMG_W+3 entry shift chain holds the two previous rows plus the current row's tail.
module pixel_window_buf #(
    parameter int IMG_W = 38,
    parameter int IMG_H = 30,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            i_valid,
    input  logic [DW-1:0]   i_data,
    output logic            o_valid,
    output logic [9*DW-1:0] o_win,
    output logic            o_eof
);

    localparam int DEPTH = 2 * IMG_W + 3;
    localparam int CW    = 10;

    logic [DW-1:0]   chain [DEPTH];
    logic [CW-1:0]   col;
    logic [CW-1:0]   row;
    logic            accept;
    logic            last_col;
    logic            last_row;
    logic            win_ok;
    logic [9*DW-1:0] win_next;

    // col/row hold the frame position the next accepted pixel will occupy.
    assign accept   = i_valid & ~clear;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == CW'(IMG_H - 1));
    assign win_ok   = (row >= CW'(2)) && (col >= CW'(2));

    // Window as it will stand once i_data has been shifted in.
    always_comb begin
        win_next                = '0;
        win_next[DW*0 +: DW]    = chain[2*IMG_W+1];
        win_next[DW*1 +: DW]    = chain[2*IMG_W];
        win_next[DW*2 +: DW]    = chain[2*IMG_W-1];
        win_next[DW*3 +: DW]    = chain[IMG_W+1];
        win_next[DW*4 +: DW]    = chain[IMG_W];
        win_next[DW*5 +: DW]    = chain[IMG_W-1];
        win_next[DW*6 +: DW]    = chain[1];
        win_next[DW*7 +: DW]    = chain[0];
        win_next[DW*8 +: DW]    = i_data;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            chain[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col     <= '0;
            row     <= '0;
            o_valid <= 1'b0;
            o_eof   <= 1'b0;
            o_win   <= '0;
        end else if (clear) begin
            col     <= '0;
            row     <= '0;
            o_valid <= 1'b0;
            o_eof   <= 1'b0;
        end else if (accept) begin
            o_valid <= win_ok;
            o_eof   <= last_row && last_col;
            o_win   <= win_next;
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end else begin
            o_valid <= 1'b0;
            o_eof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_window_buf.sv
// Bench for pixel_window_buf: a 4x4 instance for directed frames and a default
// 38x30 instance for a randomly stalled frame, both checked against a frame-image model.
module tb_pixel_window_buf;

    localparam int DW = 8;
    localparam int VW = 9 * DW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            clear;
    logic [1:0]      iv;
    logic [DW-1:0]   i_data;
    logic            ov0, ov1, eof0, eof1;
    logic [9*DW-1:0] win0, win1;

    pixel_window_buf #(.IMG_W(4), .IMG_H(4), .DW(DW)) u_small (
        .clk(clk), .rst(rst), .clear(clear), .i_valid(iv[0]), .i_data(i_data),
        .o_valid(ov0), .o_win(win0), .o_eof(eof0)
    );

    pixel_window_buf u_big (
        .clk(clk), .rst(rst), .clear(clear), .i_valid(iv[1]), .i_data(i_data),
        .o_valid(ov1), .o_win(win1), .o_eof(eof1)
    );

    int            nvec = 0;
    int            nerr = 0;
    int            nwin [2];
    int            neof [2];
    logic          exp_v [2];
    logic [VW-1:0] exp_q0 [$];
    logic [VW-1:0] exp_q1 [$];
    int            mrow [2];
    int            mcol [2];
    logic [DW-1:0] img [2][30][38];

    function automatic int wdt(input int s);
        return (s == 0) ? 4 : 38;
    endfunction

    function automatic int hgt(input int s);
        return (s == 0) ? 4 : 30;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_nonempty(input string tag, input int size);
        nvec++;
        assert (size != 0) else begin
            nerr++;
            $error("FAIL %s: observed output with empty expected queue", tag);
        end
    endtask

    // One clock of stimulus to instance s; expected windows are queued here.
    task automatic step(input int s, input bit v, input logic [DW-1:0] d, input bit c);
        logic          qual [2];
        logic [VW-1:0] e;
        int            r, cc;
        qual   = '{1'b0, 1'b0};
        iv     = '0;
        iv[s]  = v;
        i_data = d;
        clear  = c;
        if (c) begin
            mrow = '{0, 0};
            mcol = '{0, 0};
        end else if (v) begin
            r  = mrow[s];
            cc = mcol[s];
            img[s][r][cc] = d;
            if (r >= 2 && cc >= 2) begin
                e = '0;
                for (int wr = 0; wr < 3; wr++)
                    for (int wc = 0; wc < 3; wc++)
                        e[DW*(3*wr+wc) +: DW] = img[s][r-2+wr][cc-2+wc];
                e[VW-1] = (r == hgt(s) - 1) && (cc == wdt(s) - 1);
                if (s == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
                qual[s] = 1'b1;
            end
            if (cc == wdt(s) - 1) begin
                mcol[s] = 0;
                mrow[s] = (r == hgt(s) - 1) ? 0 : r + 1;
            end else begin
                mcol[s] = cc + 1;
            end
        end
        @(posedge clk);
        exp_v = qual;
        #1;
        iv    = '0;
        clear = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("valid_small", ov0, exp_v[0]);
        chk("valid_big", ov1, exp_v[1]);
        if (ov0 || eof0) begin
            nwin[0] += int'(ov0);
            neof[0] += int'(eof0);
            chk_nonempty("underflow_small", exp_q0.size());
            if (exp_q0.size() != 0) chk("win_small", {eof0, win0}, exp_q0.pop_front());
        end
        if (ov1 || eof1) begin
            nwin[1] += int'(ov1);
            neof[1] += int'(eof1);
            chk_nonempty("underflow_big", exp_q1.size());
            if (exp_q1.size() != 0) chk("win_big", {eof1, win1}, exp_q1.pop_front());
        end
    end

    int w_base, e_base;
    logic [9*DW-1:0] first_win;

    initial begin
        rst    = 1'b0;
        clear  = 1'b0;
        iv     = '0;
        i_data = '0;
        exp_v  = '{1'b0, 1'b0};
        nwin   = '{0, 0};
        neof   = '{0, 0};
        mrow   = '{0, 0};
        mcol   = '{0, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {ov1, ov0}, 0);
        chk("rst_eof", {eof1, eof0}, 0);
        chk("rst_win_small", win0, 0);
        chk("rst_win_big", win1, 0);
        @(negedge clk);
        rst = 1'b1;

        // continuous 4x4 frame
        w_base = nwin[0]; e_base = neof[0];
        for (int p = 0; p < 16; p++) begin
            step(0, 1'b1, DW'(p), 1'b0);
            if (p == 10) begin
                chk("first_valid", ov0, 1);
                chk("first_win", win0, 72'h0a0908060504020100);
            end
            if (p == 15) chk("eof_pixel15", {ov0, eof0}, 2'b11);
        end
        step(0, 1'b0, '0, 1'b0);
        chk("cont_windows", nwin[0] - w_base, 4);
        chk("cont_eof", neof[0] - e_base, 1);

        // same frame with alternating idle cycles
        w_base = nwin[0]; e_base = neof[0];
        for (int p = 0; p < 16; p++) begin
            step(0, 1'b1, DW'(p), 1'b0);
            step(0, 1'b0, 8'hee, 1'b0);
        end
        step(0, 1'b0, '0, 1'b0);
        chk("toggle_windows", nwin[0] - w_base, 4);
        chk("toggle_eof", neof[0] - e_base, 1);

        // two frames back to back
        w_base = nwin[0]; e_base = neof[0];
        for (int p = 0; p < 32; p++) begin
            step(0, 1'b1, DW'(p), 1'b0);
            if (p == 26) chk("frame2_first_win", {ov0, win0}, {1'b1, 72'h1a1918161514121110});
        end
        step(0, 1'b0, '0, 1'b0);
        chk("two_frame_windows", nwin[0] - w_base, 8);
        chk("two_frame_eof", neof[0] - e_base, 2);

        // clear together with a pixel mid-frame
        for (int p = 0; p < 7; p++) step(0, 1'b1, DW'(p), 1'b0);
        step(0, 1'b1, 8'd7, 1'b1);
        w_base = nwin[0];
        for (int p = 0; p < 10; p++) step(0, 1'b1, DW'(40 + p), 1'b0);
        step(0, 1'b0, '0, 1'b0);
        chk("clear_no_early_win", nwin[0] - w_base, 0);
        step(0, 1'b1, 8'd50, 1'b0);
        step(0, 1'b0, '0, 1'b0);
        chk("clear_win_after_11", nwin[0] - w_base, 1);
        for (int p = 11; p < 16; p++) step(0, 1'b1, DW'(40 + p), 1'b0);
        step(0, 1'b0, '0, 1'b0);

        // asynchronous reset mid-frame, right after a window was emitted
        for (int p = 0; p < 11; p++) step(0, 1'b1, DW'(100 + p), 1'b0);
        first_win = win0;
        chk("pre_rst_valid", ov0, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", ov0, 0);
        chk("async_rst_win", win0, 0);
        exp_v = '{1'b0, 1'b0};
        exp_q0.delete();
        mrow = '{0, 0};
        mcol = '{0, 0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        w_base = nwin[0]; e_base = neof[0];
        for (int p = 0; p < 16; p++) step(0, 1'b1, DW'(200 + p), 1'b0);
        step(0, 1'b0, '0, 1'b0);
        chk("post_rst_windows", nwin[0] - w_base, 4);
        chk("post_rst_eof", neof[0] - e_base, 1);

        // default geometry with random stalls
        w_base = nwin[1]; e_base = neof[1];
        for (int p = 0; p < 38 * 30; ) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1, 1'b0, DW'($urandom_range(0, 255)), 1'b0);
            end else begin
                step(1, 1'b1, DW'($urandom_range(0, 255)), 1'b0);
                p++;
            end
        end
        step(1, 1'b0, '0, 1'b0);
        chk("big_windows", nwin[1] - w_base, 1008);
        chk("big_eof", neof[1] - e_base, 1);

        chk("small_q_drained", exp_q0.size(), 0);
        chk("big_q_drained", exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pixel_window_buf.md
PIXEL_WINDOW_BUF -- requirements
Module: pixel_window_buf

Interface
REQ-001 Parameter IMG_W, default 38: pixels per image row; legal range 3..1023.
REQ-002 Parameter IMG_H, default 30: rows per frame; legal range 3..1023.
REQ-003 Parameter DW, default 8: pixel width in bits.
REQ-004 Port clk  input  1  clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset; asynchronous assertion, active-low.
REQ-006 Port clear  input  1  synchronous restart of the frame position.
REQ-007 Port i_valid  input  1  i_data carries a pixel this cycle.
REQ-008 Port i_data  input  DW  pixel value, raster order (row-major, left to right).
REQ-009 Port o_valid  output  1  o_win holds a complete 3x3 window this cycle.
REQ-010 Port o_win  output  9*DW  window; slice k = 3*r + c at bits [DW*k +: DW]; r=0 is the oldest row, c=0 the leftmost column.
REQ-011 Port o_eof  output  1  one-cycle pulse marking the last pixel of a frame.

Function
REQ-012 Storage SHALL be a pixel shift chain of 2*IMG_W+3 entries; each cycle with i_valid=1 and clear=0 SHALL shift i_data in as the newest entry.
REQ-013 No shift SHALL occur on cycles with i_valid=0; the chain, counters and o_win SHALL hold.
REQ-014 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL give the position of the newest accepted pixel; col SHALL wrap IMG_W-1 -> 0 and increment row.
REQ-015 A window SHALL be emitted when the accepted pixel has row>=2 and col>=2; windows straddling a row boundary (col 0 or 1) SHALL never be emitted.
REQ-016 Latency: o_valid and o_win SHALL be registered, asserted exactly 1 cycle after the accepting edge, for one cycle per qualifying pixel.
REQ-017 o_win SHALL contain pixels at (row-2..row, col-2..col) at the accepting edge; its contents are don't-care when o_valid=0.
REQ-018 Windows per frame SHALL equal (IMG_H-2)*(IMG_W-2).
REQ-019 Accepting pixel (IMG_H-1, IMG_W-1) SHALL pulse o_eof in the same output cycle as its o_valid, and SHALL wrap row and col to 0 so the next pixel starts a new frame.
REQ-020 After a frame wrap, no window SHALL be emitted until rows 0..2 of the new frame are present; stale previous-frame pixels SHALL never appear in an emitted window.
REQ-021 clear=1 SHALL set row=0, col=0, o_valid=0, o_eof=0 on the next edge; chain contents are don't-care.
REQ-022 clear=1 together with i_valid=1: clear wins; the pixel is discarded and not counted.
REQ-023 Back-to-back i_valid on every cycle SHALL be sustained with no stalls; the block has no backpressure.

Reset
REQ-024 rst=0 SHALL asynchronously force row=0, col=0, o_valid=0, o_eof=0, o_win=0.
REQ-025 Deassertion of rst mid-frame SHALL start a fresh frame; the first pixel accepted after deassertion is pixel (0,0).

Verification
REQ-026 IMG_W=4, IMG_H=4, DW=8, pixels 0..15 continuous -> 4 windows. First window on the cycle after pixel 10: o_win slices k0..k8 = 0,1,2,4,5,6,8,9,10. o_eof=1 with the 4th window after pixel 15.
REQ-027 Same stream with i_valid toggling 1,0,1,0 -> identical 4 windows in the same order; o_valid never high two cycles after an idle input cycle.
REQ-028 Two frames back to back (32 pixels) -> 8 windows, 2 o_eof pulses. The second frame's first window is after pixel 26 and contains only second-frame pixels.
REQ-029 clear asserted together with i_valid at pixel 7 -> pixel 7 dropped; the next accepted pixel is (0,0); no window until 11 further pixels have been accepted.
REQ-030 rst pulsed low mid-frame -> o_valid=0 and o_win=0 immediately, without a clock edge; the frame restarts at (0,0) after release.
REQ-031 Defaults (38x30), random stall pattern -> exactly 1008 windows and 1 o_eof; each window matches a reference model computed from (row, col).
